// File: rtl/namco_cpuctl_latch_pkg.sv
// Shared constants for the Namco CPU-control latch bank.
package namco_cpuctl_pkg;

  // AD[3:2] function codes; code 3 is reserved.
  localparam logic [1:0] FN_IRQEN = 2'd0;
  localparam logic [1:0] FN_NMIEN = 2'd1;
  localparam logic [1:0] FN_RST   = 2'd2;

  // AD[1:0] can address at most four CPUs.
  localparam int unsigned MAX_CPU = 4;

endpackage

// File: rtl/namco_cpuctl_latch_if.sv
// Main-CPU bus side and sub-CPU control vectors of the CPU-control latch bank.
interface namco_cpuctl_latch_if #(
  parameter int unsigned NCPU = 3
) ();

  logic [3:0]      AD;
  logic            WR;
  logic            DI;
  logic            VBLK;
  logic [NCPU-1:0] IACK;
  logic [NCPU-1:0] RSTS;
  logic [NCPU-1:0] IRQS;
  logic [NCPU-1:0] NMIS;

  modport master (
    output AD, WR, DI, VBLK, IACK,
    input  RSTS, IRQS, NMIS
  );

  modport slave (
    input  AD, WR, DI, VBLK, IACK,
    output RSTS, IRQS, NMIS
  );

endinterface

// File: rtl/namco_periodic_tick.sv
// Free-running prescaler plus period counter; o_tick is high for the one cycle in
// which both counters wrap, i.e. once every DIV*PERIOD clocks.
module namco_periodic_tick #(
  parameter int unsigned DIV    = 16,
  parameter int unsigned PERIOD = 12500
) (
  input  logic CL,
  input  logic RESET_N,
  output logic o_tick
);

  localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned PerW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [DivW-1:0] r_pre, w_pre_nxt;
  logic [PerW-1:0] r_per, w_per_nxt;
  logic            w_pre_wrap, w_per_wrap;

  // Next counter values with explicit wrap at each limit.
  always_comb begin
    w_pre_wrap = (r_pre == DivW'(DIV - 1));
    w_per_wrap = (r_per == PerW'(PERIOD - 1));
    w_pre_nxt  = w_pre_wrap ? '0 : r_pre + 1'b1;
    w_per_nxt  = r_per;
    if (w_pre_wrap) begin
      w_per_nxt = w_per_wrap ? '0 : r_per + 1'b1;
    end
    o_tick = w_pre_wrap & w_per_wrap;
  end

  // Counter state; restarts from zero on reset.
  always_ff @(posedge CL or negedge RESET_N) begin
    if (!RESET_N) begin
      r_pre <= '0;
      r_per <= '0;
    end else begin
      r_pre <= w_pre_nxt;
      r_per <= w_per_nxt;
    end
  end

endmodule

// File: rtl/namco_cpuctl_latch.sv
// CPU-control latch bank: per-CPU IRQ/NMI enable and pending latches, software
// reset holds, VBLANK rising-edge IRQ capture and a periodic timer NMI.
module namco_cpuctl_latch
  import namco_cpuctl_pkg::*;
#(
  parameter int unsigned     NCPU         = 3,
  parameter int unsigned     NMI_PRESCALE = 16,
  parameter int unsigned     NMI_PERIOD   = 12500,
  parameter logic [NCPU-1:0] NMI_CPUS     = 3'b100,
  parameter logic [NCPU-1:0] RST_CTRL     = 3'b110,
  parameter bit              NMI_EN_INV   = 1'b1
) (
  input  logic                 CL,
  input  logic                 RESET_N,
  namco_cpuctl_latch_if.slave  bus
);

  if (NCPU < 1 || NCPU > MAX_CPU) begin : g_bad_ncpu
    $error("NCPU out of range");
  end

  logic [NCPU-1:0] r_irq_en, r_irq_pend, r_nmi_en, r_nmi_pend, r_rst_hold;
  logic [NCPU-1:0] w_irq_en_nxt, w_irq_pend_nxt, w_nmi_en_nxt, w_nmi_pend_nxt;
  logic [NCPU-1:0] w_rst_hold_nxt;
  logic [NCPU-1:0] w_sel;
  logic            r_vblk_d;
  logic            w_vb_rise;
  logic            w_tick;
  logic            w_nmi_en_bit;

  namco_periodic_tick #(
    .DIV    (NMI_PRESCALE),
    .PERIOD (NMI_PERIOD)
  ) u_tick (
    .CL      (CL),
    .RESET_N (RESET_N),
    .o_tick  (w_tick)
  );

  // Next-state: set events first, then clears from IACK/disable writes layered
  // so that a disable write beats a set event and a set event beats IACK.
  always_comb begin
    w_vb_rise      = bus.VBLK & ~r_vblk_d;
    w_nmi_en_bit   = bus.DI ^ NMI_EN_INV;
    w_sel          = '0;
    w_irq_en_nxt   = r_irq_en;
    w_nmi_en_nxt   = r_nmi_en;
    w_irq_pend_nxt = (r_irq_pend & ~bus.IACK) | {NCPU{w_vb_rise}};
    w_nmi_pend_nxt = r_nmi_pend | (w_tick ? NMI_CPUS : '0);
    // CPUs outside RST_CTRL leave reset on the first edge after RESET_N rises.
    w_rst_hold_nxt = r_rst_hold & RST_CTRL;
    for (int i = 0; i < NCPU; i++) begin
      // Only indices below NCPU can match, so out-of-range writes drop out here.
      w_sel[i] = bus.WR && (bus.AD[1:0] == 2'(i));
      if (w_sel[i]) begin
        case (bus.AD[3:2])
          FN_IRQEN: begin
            w_irq_en_nxt[i] = bus.DI;
            if (!bus.DI) w_irq_pend_nxt[i] = 1'b0;
          end
          FN_NMIEN: begin
            w_nmi_en_nxt[i] = w_nmi_en_bit;
            if (!w_nmi_en_bit) w_nmi_pend_nxt[i] = 1'b0;
          end
          FN_RST: begin
            if (RST_CTRL[i]) w_rst_hold_nxt[i] = ~bus.DI;
          end
          default: ;
        endcase
      end
    end
  end

  // Latch state; reset holds every CPU in reset with nothing pending.
  always_ff @(posedge CL or negedge RESET_N) begin
    if (!RESET_N) begin
      r_irq_en   <= '0;
      r_irq_pend <= '0;
      r_nmi_en   <= '0;
      r_nmi_pend <= '0;
      r_rst_hold <= '1;
      r_vblk_d   <= 1'b0;
    end else begin
      r_irq_en   <= w_irq_en_nxt;
      r_irq_pend <= w_irq_pend_nxt;
      r_nmi_en   <= w_nmi_en_nxt;
      r_nmi_pend <= w_nmi_pend_nxt;
      r_rst_hold <= w_rst_hold_nxt;
      r_vblk_d   <= bus.VBLK;
    end
  end

  assign bus.RSTS = r_rst_hold;
  assign bus.IRQS = r_irq_en & r_irq_pend;
  assign bus.NMIS = r_nmi_en & r_nmi_pend & NMI_CPUS;

endmodule

// File: tb/tb_namco_cpuctl_latch.sv
// Self-checking bench for namco_cpuctl_latch: directed scenarios plus random
// traffic compared every cycle against a behavioural model.
module tb_namco_cpuctl_latch;

  localparam int unsigned NCPU     = 3;
  localparam int unsigned PRE      = 4;
  localparam int unsigned PER      = 5;
  localparam logic [2:0]  NMI_CPUS = 3'b100;
  localparam logic [2:0]  RST_CTRL = 3'b110;
  localparam bit          NMI_INV  = 1'b1;

  logic CL = 1'b0;
  logic RESET_N = 1'b0;
  always #5 CL = ~CL;

  namco_cpuctl_latch_if #(.NCPU(NCPU)) bus_if ();

  namco_cpuctl_latch #(
    .NCPU         (NCPU),
    .NMI_PRESCALE (PRE),
    .NMI_PERIOD   (PER),
    .NMI_CPUS     (NMI_CPUS),
    .RST_CTRL     (RST_CTRL),
    .NMI_EN_INV   (NMI_INV)
  ) dut (
    .CL      (CL),
    .RESET_N (RESET_N),
    .bus     (bus_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state.
  logic [2:0] m_irq_en, m_irq_pend, m_nmi_en, m_nmi_pend, m_hold;
  logic       m_vb;
  int         m_edges;

  task automatic check_eq(input string tag, input logic [NCPU-1:0] got,
                          input logic [NCPU-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_irq_en = '0; m_irq_pend = '0; m_nmi_en = '0; m_nmi_pend = '0;
    m_hold = '1; m_vb = 1'b0; m_edges = 0;
  endtask

  // One clock edge of the spec's rules: set events, then IACK loses to VBLANK,
  // and disable writes beat any set event.
  task automatic model_step(input logic [3:0] ad, input logic wr, input logic di,
                            input logic vblk, input logic [2:0] iack);
    logic vb_rise;
    logic en;
    int   k;
    vb_rise = vblk && !m_vb;
    m_vb = vblk;
    m_edges++;
    m_hold &= RST_CTRL;
    m_irq_pend &= ~iack;
    if (vb_rise) m_irq_pend = '1;
    if (m_edges % (PRE * PER) == 0) m_nmi_pend |= NMI_CPUS;
    k = int'(ad[1:0]);
    if (wr && k < NCPU) begin
      case (ad[3:2])
        2'd0: begin
          m_irq_en[k] = di;
          if (!di) m_irq_pend[k] = 1'b0;
        end
        2'd1: begin
          en = di ^ NMI_INV;
          m_nmi_en[k] = en;
          if (!en) m_nmi_pend[k] = 1'b0;
        end
        2'd2: if (RST_CTRL[k]) m_hold[k] = ~di;
        default: ;
      endcase
    end
  endtask

  task automatic check_model(input string tag);
    check_eq({tag, ".rsts"}, bus_if.RSTS, m_hold);
    check_eq({tag, ".irqs"}, bus_if.IRQS, m_irq_en & m_irq_pend);
    check_eq({tag, ".nmis"}, bus_if.NMIS, m_nmi_en & m_nmi_pend & NMI_CPUS);
  endtask

  // Drive one cycle of inputs, let an edge pass, then compare against the model.
  task automatic cycle(input string tag, input logic [3:0] ad, input logic wr,
                       input logic di, input logic vblk, input logic [2:0] iack);
    bus_if.AD = ad; bus_if.WR = wr; bus_if.DI = di;
    bus_if.VBLK = vblk; bus_if.IACK = iack;
    @(posedge CL);
    model_step(ad, wr, di, vblk, iack);
    #1;
    check_model(tag);
  endtask

  task automatic idle(input string tag, input logic vblk);
    cycle(tag, 4'h0, 1'b0, 1'b0, vblk, 3'b000);
  endtask

  logic [2:0] snap_rsts, snap_irqs, snap_nmis;

  initial begin
    bus_if.AD = '0; bus_if.WR = 1'b0; bus_if.DI = 1'b0;
    bus_if.VBLK = 1'b0; bus_if.IACK = '0;
    model_reset();
    repeat (3) @(posedge CL);
    #1;
    check_eq("rst.rsts", bus_if.RSTS, 3'b111);
    check_eq("rst.irqs", bus_if.IRQS, 3'b000);
    check_eq("rst.nmis", bus_if.NMIS, 3'b000);
    #1 RESET_N = 1'b1;

    // Reset release and software release of CPU1.
    idle("rel", 1'b0);
    check_eq("rel_rsts", bus_if.RSTS, 3'b110);
    cycle("swrel", 4'b1001, 1'b1, 1'b1, 1'b0, 3'b000);
    check_eq("swrel_rsts", bus_if.RSTS, 3'b100);

    // Timer NMI to CPU2: enable (DI=0 with inverted enable) and wait 20 edges.
    cycle("nmien", 4'b0110, 1'b1, 1'b0, 1'b0, 3'b000);
    cycle("irqen0", 4'h0, 1'b1, 1'b1, 1'b0, 3'b000);
    while (m_edges < 19) idle("nmiwait", 1'b0);
    check_eq("nmi_pre", bus_if.NMIS, 3'b000);
    idle("nmi20", 1'b0);
    check_eq("nmi_20", bus_if.NMIS, 3'b100);

    // VBLANK held high: one capture, IACK clears, no re-set while held.
    idle("vb_rise", 1'b1);
    check_eq("vb_irq0", bus_if.IRQS, 3'b001);
    repeat (10) idle("vb_hold", 1'b1);
    check_eq("vb_held", bus_if.IRQS, 3'b001);
    cycle("iack0", 4'h0, 1'b0, 1'b0, 1'b1, 3'b001);
    check_eq("iack_clr", bus_if.IRQS, 3'b000);
    repeat (88) idle("vb_hold2", 1'b1);
    check_eq("vb_norest", bus_if.IRQS, 3'b000);
    idle("vb_low", 1'b0);

    // Pending retained while disabled; disable write beats a VBLANK rise.
    idle("vb_rise2", 1'b1);
    cycle("irqen1", 4'h1, 1'b1, 1'b1, 1'b1, 3'b000);
    check_eq("irq1_ret", bus_if.IRQS, 3'b011);
    idle("vb_low2", 1'b0);
    cycle("dis1_vb", 4'h1, 1'b1, 1'b0, 1'b1, 3'b000);
    check_eq("dis_wins", bus_if.IRQS, 3'b001);

    // NMI disable (DI=1).
    cycle("nmidis", 4'b0110, 1'b1, 1'b1, 1'b1, 3'b000);
    check_eq("nmi_off", bus_if.NMIS, 3'b000);

    // Out-of-range CPU index and reserved function leave outputs untouched.
    snap_rsts = m_hold;
    snap_irqs = m_irq_en & m_irq_pend;
    snap_nmis = m_nmi_en & m_nmi_pend & NMI_CPUS;
    for (int i = 0; i < 8; i++) begin
      logic [3:0] ad;
      ad = (i < 4) ? 4'(i * 4 + 3) : 4'(12 + (i - 4));
      cycle("ign", ad, 1'b1, i[0], 1'b1, 3'b000);
      check_eq("ign_rsts", bus_if.RSTS, snap_rsts);
      check_eq("ign_irqs", bus_if.IRQS, snap_irqs);
      check_eq("ign_nmis", bus_if.NMIS, snap_nmis);
    end

    // Random traffic against the model.
    begin
      logic vb;
      vb = 1'b1;
      for (int n = 0; n < 1500; n++) begin
        logic [2:0] ia;
        if ($urandom_range(0, 7) == 0) vb = ~vb;
        ia = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000;
        cycle("rnd", 4'($urandom), 1'($urandom), 1'($urandom), vb, ia);
      end
    end

    // Asynchronous reset mid-operation with IRQS/NMIS high.
    idle("pre_low", 1'b0);
    cycle("en0", 4'h0, 1'b1, 1'b1, 1'b0, 3'b000);
    cycle("en1", 4'h1, 1'b1, 1'b1, 1'b0, 3'b000);
    cycle("en2", 4'h2, 1'b1, 1'b1, 1'b0, 3'b000);
    cycle("nen2", 4'b0110, 1'b1, 1'b0, 1'b0, 3'b000);
    idle("vb_all", 1'b1);
    check_eq("irq_all", bus_if.IRQS, 3'b111);
    for (int i = 0; i < 2 * PRE * PER && bus_if.NMIS[2] !== 1'b1; i++) idle("nmi_w2", 1'b1);
    check_eq("nmi_wait", bus_if.NMIS, 3'b100);
    repeat (7) idle("mid", 1'b1);
    RESET_N = 1'b0;
    #1;
    check_eq("async.rsts", bus_if.RSTS, 3'b111);
    check_eq("async.irqs", bus_if.IRQS, 3'b000);
    check_eq("async.nmis", bus_if.NMIS, 3'b000);
    model_reset();
    bus_if.VBLK = 1'b0;
    repeat (2) @(posedge CL);
    #2 RESET_N = 1'b1;
    cycle("rel2", 4'b0110, 1'b1, 1'b0, 1'b0, 3'b000);
    check_eq("rel2_rsts", bus_if.RSTS, 3'b110);
    while (m_edges < PRE * PER - 1) idle("t2wait", 1'b0);
    check_eq("t2_pre", bus_if.NMIS, 3'b000);
    idle("t2", 1'b0);
    check_eq("t2_tick", bus_if.NMIS, 3'b100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/namco_cpuctl_latch.md
Name: namco_cpuctl_latch

Overview:
- Parametrised CPU-control latch bank for Namco multi-CPU boards: per-CPU IRQ enable and pending latches, per-CPU NMI enable and pending latches, and per-CPU software reset holds.
- Sits beside the I/O decoder on the main CPU bus and drives the RSTS/IRQS/NMIS vectors of all sub-CPUs.
- Extends the fixed 3-CPU latch with:
  - configurable CPU count;
  - rising-edge VBLANK capture;
  - interrupt-acknowledge clearing;
  - a parametrised periodic NMI timer;
  - masks for which CPUs take the timer NMI and which CPUs have software reset control.

Parameters:
- NCPU, 3, number of CPUs served (1..4).
- NMI_PRESCALE, 16, CL cycles per timer sub-tick (>=2).
- NMI_PERIOD, 12500, sub-ticks per NMI event (>=2); the defaults give 120 Hz at a 24 MHz CL.
- NMI_CPUS, 3'b100, bitmask [NCPU-1:0] of CPUs that receive timer NMIs.
- RST_CTRL, 3'b110, bitmask [NCPU-1:0] of CPUs whose reset is software-held. CPUs not in the mask are released automatically.
- NMI_EN_INV, 1, when 1 the NMI enable latch stores ~DI; when 0 it stores DI.

Ports:
- CL  in  1  system clock.
- RESET_N  in  1  reset, asynchronous assert, active-low.
- AD  in  4  latch address: AD[3:2] = function, AD[1:0] = CPU index.
- WR  in  1  write strobe, one CL cycle per write, pre-qualified by the address decoder.
- DI  in  1  write data bit (bus D0).
- VBLK  in  1  vertical blank, synchronous to CL.
- IACK  in  NCPU  per-CPU interrupt-acknowledge pulse; clears IRQ pending.
- RSTS  out  NCPU  per-CPU reset, active-high.
- IRQS  out  NCPU  per-CPU IRQ request, active-high level.
- NMIS  out  NCPU  per-CPU NMI request, active-high level.

Behaviour:
- One clock, CL. RESET_N is asynchronous and active-low. All state is updated on the CL rising edge.
- Reset values (RESET_N=0):
  - all IRQ_EN, IRQ_PEND, NMI_EN, NMI_PEND = 0;
  - RST_HOLD = all ones;
  - VBLK edge register = 0;
  - prescaler and period counters = 0;
  - RSTS = all ones, IRQS = 0, NMIS = 0.
- Write decode applies when WR=1 and index k=AD[1:0] < NCPU; writes with k >= NCPU are ignored.
  - Function 0: IRQ_EN[k] <= DI. DI=0 also clears IRQ_PEND[k].
  - Function 1: NMI_EN[k] <= DI^NMI_EN_INV. If the resulting enable is 0, NMI_PEND[k] is cleared.
  - Function 2: if RST_CTRL[k], RST_HOLD[k] <= ~DI; otherwise the write is ignored.
  - Function 3: reserved, write ignored.
- VBLANK capture:
  - vb_rise = VBLK & ~VBLK_d.
  - On vb_rise, IRQ_PEND[k] is set for every k, whether or not IRQ_EN[k] is set.
  - A VBLK level held high sets pending only once.
- IACK[k]=1 clears IRQ_PEND[k].
- NMI timer:
  - The prescaler counts 0..NMI_PRESCALE-1. On its wrap, the period counter advances through 0..NMI_PERIOD-1.
  - tick is asserted for the single CL cycle in which both counters wrap together, i.e. once per NMI_PRESCALE*NMI_PERIOD cycles.
  - On tick, NMI_PEND[k] is set for every k with NMI_CPUS[k]=1.
  - The timer free-runs from reset and is unaffected by writes.
- Reset release:
  - For k not in RST_CTRL, RST_HOLD[k] clears on the first CL edge after RESET_N deasserts.
  - For k in RST_CTRL, RST_HOLD[k] stays 1 until software releases it.
- Outputs are combinational from registers only: RSTS = RST_HOLD, IRQS = IRQ_EN & IRQ_PEND, NMIS = NMI_EN & NMI_PEND & NMI_CPUS.
- Latency: one CL edge from the causing event (write, VBLK rise, tick, IACK) to the output change.
- Simultaneous events:
  - Disable write together with set event (vb_rise/tick): disable wins, pending ends 0.
  - Enable write together with set event: pending 1, enable 1, request asserted after that edge.
  - IACK[k] together with vb_rise: set wins, pending stays 1 (new frame event).
  - Write to CPU k and IACK[j], j != k: independent.
- A CPU held in reset still latches pending events; the bits survive release.
- RESET_N asserted mid-operation forces the reset values immediately and asynchronously. The timer restarts from 0.
- All counters wrap explicitly at their limits and never reach out-of-range values. Counter widths are $clog2 of the limit.

Decomposition:
- Shared package namco_cpuctl_pkg holds:
  - function-code constants FN_IRQEN=2'd0, FN_NMIEN=2'd1, FN_RST=2'd2;
  - MAX_CPU=4.
- One natural sub-module, namco_periodic_tick (prescaler plus period counter, single-cycle tick output), parameters DIV and PERIOD. It is reusable for other timed strobes.

Test Plan:
- Reset then release, NCPU=3, RST_CTRL=3'b110 -> RSTS=3'b111 during reset, RSTS=3'b110 one edge after release. Write AD=4'b1001, DI=1 -> RSTS=3'b100.
- Write AD=4'h0 DI=1, pulse VBLK high for 100 cycles -> IRQS[0]=1 one edge after the rise and stays 1. IACK[0] pulse -> IRQS[0]=0. VBLK still high -> no re-set.
- Leave IRQ disabled, VBLK rise, then write AD=4'h1 DI=1 -> IRQS[1]=1 immediately after the write (pending retained). Write AD=4'h1 DI=0 together with a VBLK rise -> IRQS[1]=0.
- NMI_PRESCALE=4, NMI_PERIOD=5, NMI_EN_INV=1: write AD=4'b0110 DI=0 (enable) -> NMIS[2] rises 20 cycles after reset release. Write DI=1 -> NMIS[2]=0. Other CPUs never assert NMIS.
- Writes to AD[1:0]=3 with NCPU=3, and any write to function 3 -> no output change.
- RESET_N asserted while IRQS/NMIS are high and mid timer count -> outputs drop asynchronously. After release the first tick occurs exactly NMI_PRESCALE*NMI_PERIOD cycles later.
